serial_write_buffer: RTL and testbench
======================================

# serial_write_buffer

Parallel-in, serial-out transmit buffer. Loads a BUF_SIZE-bit word on a start strobe, then drives it onto a single serial line one bit per external write strobe, MSB first. Sits between protocol logic and an output pin. The bit-clock of the external interface is reduced to a one-cycle strobe (write_sig) by a companion edge detector outside this block.

## Interface
- BUF_SIZE, 8: word width in bits (≥2).
- sys_clk  in  1  system clock; all state changes on its rising edge.
- rst  in  1  asynchronous, active-low reset (asserted = 0).
- start  in  1  load data_in and begin a transfer; sampled at a rising edge of sys_clk.
- write_sig  in  1  one-cycle strobe: the current bit has been consumed, so advance to the next bit.
- data_in  in  BUF_SIZE  word to transmit; sampled only when start is accepted.
- data_out  out  1  current serial bit.
- done_sig  out  1  level; 1 = idle/transfer complete, 0 = transfer in progress.

## Operation
- States: IDLE, SHIFT.
- Reset (rst=0, any time, including mid-transfer): state=IDLE, data_out=0, done_sig=1, shift register and bit counter cleared. An aborted word is discarded and never resumes.
- IDLE:
  - start=1 loads data_in into the shift register.
  - data_out = data_in[BUF_SIZE-1].
  - Bit counter = 0, done_sig = 0, go to SHIFT.
  - write_sig is ignored in IDLE.
- SHIFT, on each write_sig:
  - Counter increments.
  - If counter reaches BUF_SIZE: go to IDLE, done_sig = 1, data_out = 0.
  - Otherwise data_out = next lower bit.
- start is ignored while in SHIFT.
- start and write_sig in the same cycle while in IDLE: start wins and the strobe is ignored.
- Counter width is $clog2(BUF_SIZE+1).

## Timing
- data_out shows bit BUF_SIZE-1 in the cycle after start is accepted. done_sig falls in that same cycle.
- Each bit stays on data_out until the cycle after its write_sig. The consumer therefore samples on the bit-clock rising edge, and the falling edge generates write_sig.
- done_sig rises one cycle after the BUF_SIZE-th write_sig.
- write_sig strobes may be as close as one per cycle.
- Back-to-back words: a start accepted in the cycle after done_sig rises is legal.

## Configuration
- SERIAL_WRITE_BUFFER_LSB_FIRST_EN
  - Defined: bit order is LSB first. The first bit is data_in[0]; the shift direction is reversed.
  - Undefined (default): MSB first as described above.

## Structure
- Shared package holds:
  - state enum (IDLE, SHIFT);
  - default BUF_SIZE constant;
  - a counter-width function based on $clog2.
- Natural sub-module: edge_detector, instantiated by the integrator rather than inside this block.
  - Parameter FALL_EDGE (0 = rising, 1 = falling).
  - Ports: sys_clk, rst, sig, edge_sig.
  - Synchronises sig with two flops.
  - Emits a one-cycle edge_sig on the selected edge.
  - Reset value of edge_sig is 0.
- Datapath: one shift register plus counter, inline in serial_write_buffer.

## Test plan
- Reset: after rst pulse -> done_sig=1, data_out=0, and strobes without start leave data_out=0.
- Word 0x9C, start, then 8 falling-edge strobes:
  - data_out sequence 1,0,0,1,1,1,0,0;
  - done_sig low throughout, high one cycle after the 8th strobe.
- Word 0xE4, start, rst pulsed after 3 strobes:
  - done_sig=1 and data_out=0 immediately;
  - further strobes have no effect.
- Word 0xB5 after the abort: sequence 1,0,1,1,0,1,0,1, then done_sig=1.
- start with data_in=0xFF pulsed mid-transfer of 0x00: ignored, all 8 bits read 0.
- With SERIAL_WRITE_BUFFER_LSB_FIRST_EN defined, 0x9C -> sequence 0,0,1,1,1,0,0,1.

Source files
------------

// File: rtl/serial_write_buffer_pkg.sv
`default_nettype none
// ============================================================================
// Module      : serial_write_buffer_pkg
// Description : Shared types and helpers for the serial write buffer: FSM
//               state encoding, default word width and counter sizing.
// Revision    : 1.0 - initial release
// ============================================================================
package serial_write_buffer_pkg;

   localparam int DEFAULT_BUF_SIZE = 8;

   typedef enum logic [0:0] {
      IDLE  = 1'b0,
      SHIFT = 1'b1
   } state_t;

   // Bit counter must be able to hold the value BUF_SIZE itself.
   function automatic int cnt_width(input int size);
      return $clog2(size + 1);
   endfunction

endpackage
`default_nettype wire

// File: rtl/edge_detector.sv
`default_nettype none
// ============================================================================
// Module      : edge_detector
// Description : Two-flop synchroniser followed by an edge detector. Emits a
//               one-cycle edge_sig on the rising (FALL_EDGE=0) or falling
//               (FALL_EDGE=1) edge of the asynchronous input sig. Intended to
//               turn an external bit clock into the write_sig strobe.
// Revision    : 1.0 - initial release
// ============================================================================
module edge_detector #(
   parameter bit FALL_EDGE = 1'b0
) (
   input  logic sys_clk,
   input  logic rst,
   input  logic sig,
   output logic edge_sig
);

   logic [1:0] r_sync;
   logic       r_prev;
   logic       r_edge;
   logic       w_edge;

   // Compare the synchronised level against its previous value.
   always_comb begin
      w_edge = FALL_EDGE ? (r_prev & ~r_sync[1]) : (r_sync[1] & ~r_prev);
   end

   // Synchroniser chain, history flop and registered strobe.
   always_ff @(posedge sys_clk or negedge rst) begin
      if (!rst) begin
         r_sync <= 2'b00;
         r_prev <= 1'b0;
         r_edge <= 1'b0;
      end else begin
         r_sync <= {r_sync[0], sig};
         r_prev <= r_sync[1];
         r_edge <= w_edge;
      end
   end

   assign edge_sig = r_edge;

endmodule
`default_nettype wire

// File: rtl/serial_write_buffer.sv
`default_nettype none
// ============================================================================
// Module      : serial_write_buffer
// Description : Parallel-in, serial-out transmit buffer. Loads a word on
//               start and presents one bit per write_sig strobe on data_out.
//               Bit order is MSB first; defining
//               SERIAL_WRITE_BUFFER_LSB_FIRST_EN selects LSB first.
// Revision    : 1.0 - initial release
// ============================================================================
module serial_write_buffer
   import serial_write_buffer_pkg::*;
#(
   parameter int BUF_SIZE = DEFAULT_BUF_SIZE
) (
   input  logic                sys_clk,
   input  logic                rst,
   input  logic                start,
   input  logic                write_sig,
   input  logic [BUF_SIZE-1:0] data_in,
   output logic                data_out,
   output logic                done_sig
);

   localparam int                c_cnt_w    = cnt_width(BUF_SIZE);
   localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(BUF_SIZE - 1);
   localparam logic [c_cnt_w-1:0] c_cnt_one  = c_cnt_w'(1);

   state_t                r_state;
   state_t                w_state_nxt;
   logic [BUF_SIZE-1:0]   r_shift;
   logic [BUF_SIZE-1:0]   w_shift_nxt;
   logic [BUF_SIZE-1:0]   w_shifted;
   logic [c_cnt_w-1:0]    r_cnt;
   logic [c_cnt_w-1:0]    w_cnt_nxt;
   logic                  r_done;
   logic                  w_done_nxt;

   // The output bit is taken straight from the shift register; zeros are
   // shifted in, so the line reads 0 once the last bit has been consumed.
`ifdef SERIAL_WRITE_BUFFER_LSB_FIRST_EN
   assign w_shifted = {1'b0, r_shift[BUF_SIZE-1:1]};
   assign data_out  = r_shift[0];
`else
   assign w_shifted = {r_shift[BUF_SIZE-2:0], 1'b0};
   assign data_out  = r_shift[BUF_SIZE-1];
`endif

   assign done_sig = r_done;

   // State register.
   always_ff @(posedge sys_clk or negedge rst) begin
      if (!rst) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Shift register, bit counter and done flag.
   always_ff @(posedge sys_clk or negedge rst) begin
      if (!rst) begin
         r_shift <= '0;
         r_cnt   <= '0;
         r_done  <= 1'b1;
      end else begin
         r_shift <= w_shift_nxt;
         r_cnt   <= w_cnt_nxt;
         r_done  <= w_done_nxt;
      end
   end

   // Next-state and datapath update; start has priority over write_sig in IDLE.
   always_comb begin
      w_state_nxt = r_state;
      w_shift_nxt = r_shift;
      w_cnt_nxt   = r_cnt;
      w_done_nxt  = r_done;
      case (r_state)
         IDLE: begin
            if (start) begin
               w_shift_nxt = data_in;
               w_cnt_nxt   = '0;
               w_done_nxt  = 1'b0;
               w_state_nxt = SHIFT;
            end
         end
         SHIFT: begin
            if (write_sig) begin
               w_cnt_nxt   = r_cnt + c_cnt_one;
               w_shift_nxt = w_shifted;
               if (r_cnt == c_cnt_last) begin
                  w_shift_nxt = '0;
                  w_done_nxt  = 1'b1;
                  w_state_nxt = IDLE;
               end
            end
         end
         default: begin
            w_state_nxt = IDLE;
         end
      endcase
   end

endmodule
`default_nettype wire

// File: tb/tb_serial_write_buffer.sv
`default_nettype none
// ============================================================================
// Module      : tb_serial_write_buffer
// Description : Directed self-checking bench for serial_write_buffer and the
//               companion edge_detector.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_serial_write_buffer;

   logic       sys_clk = 1'b0;
   logic       rst = 1'b1;
   logic       start = 1'b0;
   logic       write_sig = 1'b0;
   logic [7:0] data_in = 8'h00;
   logic       data_out;
   logic       done_sig;
   logic       bclk = 1'b0;
   logic       edge_rise;
   logic       edge_fall;

   int n_checks = 0;
   int n_errors = 0;

   // Transmit orders written out by hand from the words under test.
`ifdef SERIAL_WRITE_BUFFER_LSB_FIRST_EN
   localparam logic [7:0] SEQ_9C = 8'b0011_1001;
   localparam logic [7:0] SEQ_B5 = 8'b1010_1101;
   localparam logic [3:0] SEQ_E4 = 4'b0010;
`else
   localparam logic [7:0] SEQ_9C = 8'b1001_1100;
   localparam logic [7:0] SEQ_B5 = 8'b1011_0101;
   localparam logic [3:0] SEQ_E4 = 4'b1110;
`endif

   serial_write_buffer #(.BUF_SIZE(8)) dut (
      .sys_clk   (sys_clk),
      .rst       (rst),
      .start     (start),
      .write_sig (write_sig),
      .data_in   (data_in),
      .data_out  (data_out),
      .done_sig  (done_sig)
   );

   edge_detector #(.FALL_EDGE(1'b0)) u_ed_rise (
      .sys_clk  (sys_clk),
      .rst      (rst),
      .sig      (bclk),
      .edge_sig (edge_rise)
   );

   edge_detector #(.FALL_EDGE(1'b1)) u_ed_fall (
      .sys_clk  (sys_clk),
      .rst      (rst),
      .sig      (bclk),
      .edge_sig (edge_fall)
   );

   always #5 sys_clk = ~sys_clk;

   task automatic step();
      @(posedge sys_clk);
      #1;
   endtask

   task automatic check(input string tag, input logic obs, input logic exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
      end
   endtask

   // Load a word and walk it out; gap=1 inserts a hold cycle before every
   // strobe, poke re-asserts start with 0xFF mid-word, ws_first raises
   // write_sig together with start.
   task automatic send(input string tag, input logic [7:0] word,
                       input logic [7:0] seq, input bit gap, input bit poke,
                       input bit ws_first);
      data_in   = word;
      start     = 1'b1;
      write_sig = ws_first;
      step();
      start     = 1'b0;
      write_sig = 1'b0;
      check({tag, " first bit"}, data_out, seq[7]);
      check({tag, " done low at load"}, done_sig, 1'b0);
      for (int k = 0; k < 8; k++) begin
         if (gap) begin
            if (poke && k == 3) begin
               start   = 1'b1;
               data_in = 8'hFF;
            end
            step();
            start = 1'b0;
            check($sformatf("%s hold bit %0d", tag, k), data_out, seq[7-k]);
            check($sformatf("%s done low hold %0d", tag, k), done_sig, 1'b0);
         end
         write_sig = 1'b1;
         step();
         write_sig = 1'b0;
         if (k < 7) begin
            check($sformatf("%s bit %0d", tag, k + 1), data_out, seq[6-k]);
            check($sformatf("%s done low %0d", tag, k + 1), done_sig, 1'b0);
         end else begin
            check({tag, " done high"}, done_sig, 1'b1);
            check({tag, " line idle"}, data_out, 1'b0);
         end
      end
   endtask

   initial begin
      // Reset state.
      #3 rst = 1'b0;
      #1;
      check("reset done", done_sig, 1'b1);
      check("reset data", data_out, 1'b0);
      check("reset edge rise", edge_rise, 1'b0);
      step();
      step();
      rst = 1'b1;
      // Strobes with no start leave the line idle.
      for (int i = 0; i < 2; i++) begin
         write_sig = 1'b1;
         step();
         write_sig = 1'b0;
         check("idle strobe data", data_out, 1'b0);
         check("idle strobe done", done_sig, 1'b1);
      end

      send("w9C", 8'h9C, SEQ_9C, 1'b1, 1'b0, 1'b0);

      // Abort 0xE4 after three back-to-back strobes.
      data_in = 8'hE4;
      start   = 1'b1;
      step();
      start = 1'b0;
      check("E4 bit 0", data_out, SEQ_E4[3]);
      for (int k = 0; k < 3; k++) begin
         write_sig = 1'b1;
         step();
         write_sig = 1'b0;
         check($sformatf("E4 bit %0d", k + 1), data_out, SEQ_E4[2-k]);
         check($sformatf("E4 done low %0d", k + 1), done_sig, 1'b0);
      end
      rst = 1'b0;
      #1;
      check("abort done async", done_sig, 1'b1);
      check("abort data async", data_out, 1'b0);
      step();
      rst = 1'b1;
      for (int k = 0; k < 3; k++) begin
         write_sig = 1'b1;
         step();
         write_sig = 1'b0;
         check($sformatf("post-abort data %0d", k), data_out, 1'b0);
         check($sformatf("post-abort done %0d", k), done_sig, 1'b1);
      end

      // Strobes every cycle, then a back-to-back word with a stray start.
      send("wB5", 8'hB5, SEQ_B5, 1'b0, 1'b0, 1'b0);
      send("w00", 8'h00, 8'h00, 1'b1, 1'b1, 1'b0);
      // start and write_sig together in IDLE: the strobe must not count.
      send("w9C-ws", 8'h9C, SEQ_9C, 1'b0, 1'b0, 1'b1);

      // Edge detector: strobe appears on the third edge after sig moves.
      bclk = 1'b1;
      for (int k = 0; k < 4; k++) begin
         step();
         check($sformatf("rise edge %0d", k), edge_rise, (k == 2));
         check($sformatf("fall quiet %0d", k), edge_fall, 1'b0);
      end
      bclk = 1'b0;
      for (int k = 0; k < 4; k++) begin
         step();
         check($sformatf("fall edge %0d", k), edge_fall, (k == 2));
         check($sformatf("rise quiet %0d", k), edge_rise, 1'b0);
      end

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
`default_nettype wire
